// File: rtl/spi_xfer_seq_pkg.sv
// Shared constants for the spi_master byte-stream sequencer: FSM encodings,
// transfer size limit and the byte-slot position helper (byte 0 at the MSB end).
package spi_xfer_seq_pkg;

    localparam int unsigned MAX_BYTES = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_REQ   = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    function automatic int unsigned slot_msb(input int unsigned idx);
        return 127 - 8 * idx;
    endfunction

endpackage

// File: rtl/spi_seq_bytebuf.sv
// 16-byte buffer: indexed byte write, parallel load and MSB-first byte shift-out.
// Used once to pack tx bytes and once to unpack the received word.
module spi_seq_bytebuf
    import spi_xfer_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [3:0]   wr_idx,
    input  logic [7:0]   wr_byte,
    input  logic         ld_en,
    input  logic [127:0] ld_data,
    input  logic         shift_en,
    output logic [127:0] data_o
);

    logic [127:0] data_q;
    logic [127:0] data_d;
    logic [127:0] shifted;

    assign shifted = {data_q[119:0], 8'h00};

    // Priority: clear, parallel load, shift, then single-slot write.
    generate
        for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_slot
            localparam int unsigned MSB = slot_msb(gi);
            assign data_d[MSB -: 8] = clr                                ? 8'h00 :
                                      ld_en                              ? ld_data[MSB -: 8] :
                                      shift_en                           ? shifted[MSB -: 8] :
                                      (wr_en && (wr_idx == 4'(gi)))      ? wr_byte :
                                                                           data_q[MSB -: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/spi_xfer_seq.sv
// Byte-stream front end for spi_master: packs tx bytes, runs the mst_ctrl start/busy
// handshake, then streams the received word out byte by byte.
// Build option SPI_XFER_SEQ_TIMEOUT_EN adds a REQ-state timeout with sticky err_timeout.
module spi_xfer_seq
    import spi_xfer_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [7:0]   tx_data,
    input  logic         tx_valid,
    input  logic         tx_last,
    output logic         tx_ready,
    output logic [7:0]   rx_data,
    output logic         rx_valid,
    output logic         rx_last,
    input  logic         rx_ready,
    output logic [127:0] mst_wfifo,
    output logic [7:0]   mst_ctrl,
    input  logic [127:0] mst_rfifo,
    input  logic [7:0]   mst_status,
    output logic         seq_busy,
    output logic         err_timeout
);

    logic [2:0]   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [4:0]   k_q, k_d;
    logic         tx_ready_q, tx_ready_d;
    logic [7:0]   mst_ctrl_q, mst_ctrl_d;
    logic         err_q, err_d;
    logic         tx_wr, tx_clr, rx_ld, rx_shift;
    logic         tx_fire, rx_fire, timeout_hit, in_xfer;
    logic [3:0]   len4;
    logic [127:0] rx_word;
    logic         unused_bits;

`ifdef SPI_XFER_SEQ_TIMEOUT_EN
    logic [12:0] tmo_q, tmo_d;

    assign tmo_d       = (state_q == ST_REQ && !mst_status[7]) ? tmo_q + 13'd1 : 13'd0;
    assign timeout_hit = (state_q == ST_REQ) && !mst_status[7] && (tmo_q == 13'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo  = (TIMEOUT_CYC == 0);
    assign timeout_hit = 1'b0;
`endif

    assign tx_fire  = tx_valid && tx_ready_q;
    assign rx_valid = (state_q == ST_DRAIN);
    assign rx_data  = rx_word[127:120];
    assign rx_last  = rx_valid && (k_q == cnt_q - 5'd1);
    assign rx_fire  = rx_valid && rx_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        err_d    = err_q;
        tx_wr    = 1'b0;
        tx_clr   = 1'b0;
        rx_ld    = 1'b0;
        rx_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_fire) begin
                    tx_wr   = 1'b1;
                    cnt_d   = 5'd1;
                    err_d   = 1'b0;
                    state_d = tx_last ? ST_REQ : ST_FILL;
                end
            end
            ST_FILL: begin
                if (tx_fire) begin
                    tx_wr = 1'b1;
                    cnt_d = cnt_q + 5'd1;
                    // The 16th byte closes the transfer even without tx_last.
                    if (tx_last || cnt_q == 5'(MAX_BYTES - 1)) begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mst_status[7]) begin
                    state_d = ST_RUN;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                    err_d   = 1'b1;
                    tx_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!mst_status[7]) begin
                    rx_ld   = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rx_fire) begin
                    rx_shift = 1'b1;
                    k_d      = k_q + 5'd1;
                    if (rx_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = 5'd0;
                        k_d     = 5'd0;
                        tx_clr  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
                k_d     = 5'd0;
            end
        endcase
    end

    // Outputs registered from the next state so they are glitch-free and zero in reset.
    assign in_xfer    = (state_d == ST_REQ) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    assign len4       = 4'(cnt_d - 5'd1);
    assign mst_ctrl_d = {state_d == ST_REQ, 3'b000, in_xfer ? len4 : 4'h0};
    assign tx_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL && cnt_d < 5'(MAX_BYTES));

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            k_q        <= '0;
            tx_ready_q <= 1'b0;
            mst_ctrl_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            tx_ready_q <= tx_ready_d;
            mst_ctrl_q <= mst_ctrl_d;
            err_q      <= err_d;
        end
    end

    spi_seq_bytebuf u_tx_buf (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (tx_clr),
        .wr_en    (tx_wr),
        .wr_idx   (cnt_q[3:0]),
        .wr_byte  (tx_data),
        .ld_en    (1'b0),
        .ld_data  ('0),
        .shift_en (1'b0),
        .data_o   (mst_wfifo)
    );

    spi_seq_bytebuf u_rx_buf (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (1'b0),
        .wr_en    (1'b0),
        .wr_idx   (4'd0),
        .wr_byte  (8'h00),
        .ld_en    (rx_ld),
        .ld_data  (mst_rfifo),
        .shift_en (rx_shift),
        .data_o   (rx_word)
    );

    assign unused_bits = ^{rx_word[119:0], mst_status[6:0]};

    assign tx_ready    = tx_ready_q;
    assign mst_ctrl    = mst_ctrl_q;
    assign seq_busy    = (state_q != ST_IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Randomized bench for spi_xfer_seq: tx driver, behavioural spi_master slave and
// rx consumer checked against a queue model of transfer segmentation.
module tb_spi_xfer_seq;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_last;
    logic         tx_ready;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_last;
    logic         rx_ready;
    logic [127:0] mst_wfifo;
    logic [7:0]   mst_ctrl;
    logic [127:0] mst_rfifo;
    logic [7:0]   mst_status;
    logic         seq_busy;
    logic         err_timeout;

    always #5 clk = ~clk;

    spi_xfer_seq #(.TIMEOUT_CYC(64)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_last     (rx_last),
        .rx_ready    (rx_ready),
        .mst_wfifo   (mst_wfifo),
        .mst_ctrl    (mst_ctrl),
        .mst_rfifo   (mst_rfifo),
        .mst_status  (mst_status),
        .seq_busy    (seq_busy),
        .err_timeout (err_timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model state: bytes to send, bytes of the open transfer, closed transfers, expected rx.
    logic [8:0]   tx_q[$];
    logic [7:0]   cur_q[$];
    int           xfer_n_q[$];
    logic [7:0]   xfer_b_q[$];
    logic [8:0]   exp_rx_q[$];

    int           mode = 0;
    bit           slave_en = 1'b1;
    int           hold_max = 4;
    bit           rx_hold_req = 1'b0;
    int           hold_cnt = 0;
    bit           tx_hold = 1'b0;
    bit           close_chk = 1'b0;
    int           sl_st = 0;
    int           sl_cnt = 0;
    int           sl_n = 0;
    logic [7:0]   sl_b [16];
    logic [127:0] sl_w;
    logic [127:0] rf;
    logic [7:0]   bv;
    logic [8:0]   e;
    logic [31:0]  pat = 32'hDEADBEEF;

    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                tx_valid = 1'b0; tx_hold = 1'b0; close_chk = 1'b0;
                tx_q.delete(); cur_q.delete(); xfer_n_q.delete(); xfer_b_q.delete(); exp_rx_q.delete();
                sl_st = 0; mst_status = 8'h00; mst_rfifo = '0; rx_ready = 1'b0; hold_cnt = 0;
            end else begin
                // tx driver and segmentation model
                if (close_chk) begin
                    check("txrdy_closed", tx_ready, 1'b0);
                    close_chk = 1'b0;
                end
                if (tx_q.size() != 0 && (tx_hold || $urandom_range(3) != 0)) begin
                    tx_valid = 1'b1;
                    {tx_last, tx_data} = tx_q[0];
                    tx_hold = 1'b1;
                    if (tx_ready) begin
                        void'(tx_q.pop_front());
                        tx_hold = 1'b0;
                        cur_q.push_back(tx_data);
                        if (tx_last || cur_q.size() == 16) begin
                            xfer_n_q.push_back(cur_q.size());
                            foreach (cur_q[i]) xfer_b_q.push_back(cur_q[i]);
                            cur_q.delete();
                            close_chk = 1'b1;
                        end
                    end
                end else begin
                    tx_valid = 1'b0;
                end

                // behavioural spi_master
                case (sl_st)
                    0: if (slave_en && mst_ctrl[7]) begin
                        if (xfer_n_q.size() == 0) begin
                            check("xfer_unexpected", 1'b1, 1'b0);
                        end else begin
                            sl_n = xfer_n_q.pop_front();
                            sl_w = '0;
                            for (int i = 0; i < sl_n; i++) begin
                                sl_b[i] = xfer_b_q.pop_front();
                                sl_w[127-8*i -: 8] = sl_b[i];
                            end
                            check("ctrl_len", mst_ctrl[6:0], 7'(sl_n - 1));
                            check("wfifo", mst_wfifo, sl_w);
                            sl_cnt = $urandom_range(3);
                            sl_st = 1;
                        end
                    end
                    1: if (sl_cnt == 0) begin
                        check("start_held", mst_ctrl[7], 1'b1);
                        mst_status = 8'h80 | 8'($urandom_range(127));
                        sl_st = 2;
                    end else begin
                        sl_cnt--;
                    end
                    2: begin
                        check("start_drop", mst_ctrl[7], 1'b0);
                        sl_cnt = $urandom_range(hold_max);
                        sl_st = 3;
                    end
                    3: if (sl_cnt == 0) begin
                        check("wfifo_hold", mst_wfifo, sl_w);
                        for (int i = 0; i < 16; i++) begin
                            if (mode == 1) bv = pat[31-8*(i%4) -: 8];
                            else if (mode == 0 && i < sl_n) bv = sl_b[i];
                            else bv = 8'($urandom);
                            rf[127-8*i -: 8] = bv;
                            if (i < sl_n) exp_rx_q.push_back({i == sl_n - 1, bv});
                        end
                        mst_rfifo = rf;
                        mst_status = 8'($urandom_range(127));
                        sl_st = 4;
                    end else begin
                        sl_cnt--;
                    end
                    default: begin
                        check("rx_lat", rx_valid, 1'b1);
                        sl_st = 0;
                    end
                endcase

                // rx consumer
                if (hold_cnt > 0) begin
                    rx_ready = 1'b0;
                    check("hold_valid", rx_valid, 1'b1);
                    if (exp_rx_q.size() != 0) check("hold_data", rx_data, exp_rx_q[0][7:0]);
                    check("hold_txrdy", tx_ready, 1'b0);
                    hold_cnt--;
                end else if (rx_valid && rx_hold_req) begin
                    rx_hold_req = 1'b0;
                    hold_cnt = 50;
                    rx_ready = 1'b0;
                end else begin
                    rx_ready = ($urandom_range(3) != 0);
                    if (rx_valid && rx_ready) begin
                        if (exp_rx_q.size() == 0) begin
                            check("rx_unexpected", 1'b1, 1'b0);
                        end else begin
                            e = exp_rx_q.pop_front();
                            check("rx_data", rx_data, e[7:0]);
                            check("rx_last", rx_last, e[8]);
                        end
                    end
                end
            end
        end
    end

    task automatic push_bytes(input int n, input bit rnd, input logic [31:0] seed_word);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = rnd ? 8'($urandom) : seed_word[31-8*(i%4) -: 8];
            tx_q.push_back({i == n - 1, b});
        end
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (t < budget && !(tx_q.size() == 0 && cur_q.size() == 0 && xfer_n_q.size() == 0 &&
               exp_rx_q.size() == 0 && sl_st == 0 && hold_cnt == 0 && !seq_busy)) begin
            @(negedge clk);
            t++;
        end
        check("xfer_done", t < budget, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t;
        tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0; rx_ready = 1'b0;
        mst_rfifo = '0; mst_status = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txrdy", tx_ready, 1'b0);
        check("rst_rxvalid", rx_valid, 1'b0);
        check("rst_ctrl", mst_ctrl, 8'h00);
        check("rst_wfifo", mst_wfifo, '0);
        check("rst_busy", seq_busy, 1'b0);
        check("rst_err", err_timeout, 1'b0);
        #3 rstn = 1'b0;
        @(negedge clk);
        check("idle_txrdy", tx_ready, 1'b1);

        mode = 0; push_bytes(4, 1'b0, 32'hA1B2C3D4); wait_done(2000);
        mode = 2; push_bytes(20, 1'b1, 32'h0); wait_done(3000);
        mode = 1; push_bytes(16, 1'b1, 32'h0); wait_done(3000);
        mode = 2; rx_hold_req = 1'b1; push_bytes(8, 1'b1, 32'h0); wait_done(3000);

        // reset in the middle of a busy spi_master phase
        mode = 0; hold_max = 40; push_bytes(10, 1'b1, 32'h0);
        t = 0;
        while (!mst_status[7] && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("busy_seen", mst_status[7], 1'b1);
        #2 rstn = 1'b1;
        #1;
        check("mid_rst_ctrl", mst_ctrl, 8'h00);
        check("mid_rst_rxvalid", rx_valid, 1'b0);
        check("mid_rst_busy", seq_busy, 1'b0);
        repeat (3) @(negedge clk);
        #3 rstn = 1'b0;
        hold_max = 4;
        @(negedge clk);
        check("post_rst_txrdy", tx_ready, 1'b1);
        push_bytes(5, 1'b1, 32'h0); wait_done(2000);

        for (int r = 0; r < 20; r++) begin
            mode = $urandom_range(2);
            hold_max = $urandom_range(12);
            push_bytes($urandom_range(24, 1), 1'b1, 32'h0);
            wait_done(4000);
        end

`ifdef SPI_XFER_SEQ_TIMEOUT_EN
        slave_en = 1'b0;
        push_bytes(3, 1'b1, 32'h0);
        t = 0;
        while (!mst_ctrl[7] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("tmo_req", mst_ctrl[7], 1'b1);
        repeat (63) @(negedge clk);
        check("tmo_err_early", err_timeout, 1'b0);
        check("tmo_busy_early", seq_busy, 1'b1);
        @(negedge clk);
        check("tmo_err", err_timeout, 1'b1);
        check("tmo_idle", seq_busy, 1'b0);
        check("tmo_txrdy", tx_ready, 1'b1);
        check("tmo_ctrl", mst_ctrl, 8'h00);
        check("tmo_wfifo", mst_wfifo, '0);
        xfer_n_q.delete(); xfer_b_q.delete();
        repeat (10) @(negedge clk);
        slave_en = 1'b1;
        push_bytes(1, 1'b1, 32'h0); wait_done(2000);
`endif
        check("err_clear", err_timeout, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
